// File: rtl/run_ctrl_pkg.sv
// Shared types and data-memory geometry for the run controller.
package run_ctrl_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } run_state_t;

  localparam int DMEM_AW = 8;
  localparam int DMEM_DW = 8;
endpackage

// File: rtl/dmem_port_mux.sv
// Data-memory port steering: the core owns the port while running,
// otherwise the host drives it and may write only when granted.
module dmem_port_mux
  import run_ctrl_pkg::*;
(
  input  logic               i_core_owns,
  input  logic               i_host_grant,
  input  logic               i_core_we,
  input  logic [DMEM_AW-1:0] i_core_addr,
  input  logic [DMEM_DW-1:0] i_core_wdata,
  input  logic               i_host_we,
  input  logic [DMEM_AW-1:0] i_host_addr,
  input  logic [DMEM_DW-1:0] i_host_wdata,
  output logic               o_mem_we,
  output logic [DMEM_AW-1:0] o_mem_addr,
  output logic [DMEM_DW-1:0] o_mem_wdata
);
  always_comb begin
    o_mem_we    = 1'b0;
    o_mem_addr  = i_host_addr;
    o_mem_wdata = i_host_wdata;
    if (i_core_owns) begin
      o_mem_we    = i_core_we;
      o_mem_addr  = i_core_addr;
      o_mem_wdata = i_core_wdata;
    end else if (i_host_grant) begin
      o_mem_we = i_host_we;
    end
  end
endmodule

// File: rtl/run_ctrl.sv
// Run controller: holds the core in reset while the host uses data memory,
// runs it on start until done or watchdog, and counts run cycles.
module run_ctrl
  import run_ctrl_pkg::*;
#(
  parameter int WATCHDOG = 50000,
  parameter int CYC_W    = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               core_done,
  output logic               core_reset,
  input  logic               core_mem_we,
  input  logic [DMEM_AW-1:0] core_addr,
  input  logic [DMEM_DW-1:0] core_wdata,
  output logic [DMEM_DW-1:0] core_rdata,
  input  logic               host_req,
  input  logic               host_we,
  input  logic [DMEM_AW-1:0] host_addr,
  input  logic [DMEM_DW-1:0] host_wdata,
  output logic               host_ack,
  output logic [DMEM_DW-1:0] host_rdata,
  output logic               mem_we,
  output logic [DMEM_AW-1:0] mem_addr,
  output logic [DMEM_DW-1:0] mem_wdata,
  input  logic [DMEM_DW-1:0] mem_rdata,
  output logic               busy,
  output logic               finished,
  output logic               timeout,
  output logic [CYC_W-1:0]   cycles
);
  localparam logic [CYC_W-1:0] WD_LIMIT = CYC_W'(WATCHDOG);

  run_state_t         r_state;
  logic               r_busy;
  logic               r_finished;
  logic               r_timeout;
  logic               r_host_ack;
  logic [DMEM_DW-1:0] r_host_rdata;
  logic [CYC_W-1:0]   r_cycles;

  logic               w_host_side;
  logic               w_core_owns;
  logic               w_host_grant;
  logic [CYC_W-1:0]   w_cycles_inc;

  function automatic logic [CYC_W-1:0] sat_inc(input logic [CYC_W-1:0] v);
    return (&v) ? v : v + CYC_W'(1);
  endfunction

  assign w_host_side  = (r_state == IDLE) || (r_state == DONE);
  assign w_core_owns  = (r_state == RUN);
  // start outranks a host request; the ack cycle blocks a repeat grant.
  assign w_host_grant = w_host_side && host_req && !r_host_ack && !start && !reset;
  assign w_cycles_inc = sat_inc(r_cycles);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_busy       <= 1'b0;
      r_finished   <= 1'b0;
      r_timeout    <= 1'b0;
      r_cycles     <= '0;
      r_host_ack   <= 1'b0;
      r_host_rdata <= '0;
    end else begin
      r_host_ack <= w_host_grant;
      if (w_host_grant) r_host_rdata <= mem_rdata;
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_state    <= ARM;
            r_busy     <= 1'b1;
            r_finished <= 1'b0;
            r_timeout  <= 1'b0;
            r_cycles   <= '0;
          end
        end
        ARM: begin
          r_state  <= RUN;
          r_cycles <= '0;
        end
        RUN: begin
          r_cycles <= w_cycles_inc;
          // A done in the watchdog cycle still counts as a clean finish.
          if (core_done) begin
            r_state    <= DONE;
            r_busy     <= 1'b0;
            r_finished <= 1'b1;
            r_timeout  <= 1'b0;
          end else if (w_cycles_inc == WD_LIMIT) begin
            r_state    <= DONE;
            r_busy     <= 1'b0;
            r_finished <= 1'b1;
            r_timeout  <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  dmem_port_mux u_mux (
    .i_core_owns  (w_core_owns),
    .i_host_grant (w_host_grant),
    .i_core_we    (core_mem_we),
    .i_core_addr  (core_addr),
    .i_core_wdata (core_wdata),
    .i_host_we    (host_we),
    .i_host_addr  (host_addr),
    .i_host_wdata (host_wdata),
    .o_mem_we     (mem_we),
    .o_mem_addr   (mem_addr),
    .o_mem_wdata  (mem_wdata)
  );

  assign core_reset = !w_core_owns;
  assign core_rdata = mem_rdata;
  assign host_ack   = r_host_ack;
  assign host_rdata = r_host_rdata;
  assign busy       = r_busy;
  assign finished   = r_finished;
  assign timeout    = r_timeout;
  assign cycles     = r_cycles;
endmodule
